diff_unit: RTL and testbench

Registered "diff" execution unit for the KGP mini-RISC ALU. Computes the bit index of the least-significant bit position at which two 32-bit operands differ, i.e. the trailing-zero count of `inreg1 ^ inreg2`. Sits beside the ALU in the execute stage and delivers its result one clock after a valid request.

---
 rtl/diff_pkg.sv | 10 +
 rtl/diff_unit_if.sv | 25 ++
 rtl/lsb_index.sv | 48 ++++
 rtl/diff_unit.sv | 48 ++++
 tb/tb_diff_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/diff_pkg.sv
// Shared constants and types for the diff execution unit.
// Default operand width and the matching result-index type.
package diff_pkg;

    localparam int DIFF_WIDTH = 32;
    localparam int DIFF_IDX_W = 6;

    typedef logic [DIFF_IDX_W-1:0] diff_idx_t;

endpackage

// File: rtl/diff_unit_if.sv
// Request/result bundle between the execute stage and the diff unit.
// in_valid qualifies inreg1/inreg2. There is no ready, so every valid cycle is accepted.
// out_valid pulses for one cycle per accepted request. out/equal hold between requests.
interface diff_unit_if
    import diff_pkg::*;
#(
    parameter int WIDTH = DIFF_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] inreg1;
    logic [WIDTH-1:0] inreg2;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             equal;

    modport master (
        output in_valid, inreg1, inreg2,
        input  out, out_valid, equal
    );

    modport slave (
        input  in_valid, inreg1, inreg2,
        output out, out_valid, equal
    );
endinterface

// File: rtl/lsb_index.sv
// Combinational trailing-zero counter. It is a log-depth tree of pairwise priority stages.
// idx is the lowest set bit of x, or WIDTH when x is all zero (zero = 1).
module lsb_index
    import diff_pkg::*;
#(
    parameter  int WIDTH = DIFF_WIDTH,
    localparam int IDX_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] x,
    output logic [IDX_W-1:0] idx,
    output logic             zero
);
    localparam int LVLS = $clog2(WIDTH);
    localparam int PAD  = 1 << LVLS;

    // Padding with zeros is harmless: padded bits never count as differing.
    logic [PAD-1:0] xp;
    assign xp = PAD'(x);

    genvar lv, n;
    for (lv = 0; lv < LVLS; lv++) begin : g_lvl
        localparam int N = PAD >> (lv + 1);
        logic [N-1:0] z;
        logic [lv:0]  ix [N];

        for (n = 0; n < N; n++) begin : g_node
            if (lv == 0) begin : g_leaf
                assign z[n]  = ~xp[2*n] & ~xp[2*n+1];
                assign ix[n] = ~xp[2*n];
            end else begin : g_pair
                logic          zl;
                logic          zh;
                logic [lv-1:0] il;
                logic [lv-1:0] ih;
                assign zl = g_lvl[lv-1].z[2*n];
                assign zh = g_lvl[lv-1].z[2*n+1];
                assign il = g_lvl[lv-1].ix[2*n];
                assign ih = g_lvl[lv-1].ix[2*n+1];
                // The low half wins unless it is all zero. Then the upper half adds the new MSB.
                assign z[n]  = zl & zh;
                assign ix[n] = zl ? {1'b1, ih} : {1'b0, il};
            end
        end
    end

    assign zero = g_lvl[LVLS-1].z[0];
    assign idx  = zero ? IDX_W'(WIDTH) : {1'b0, g_lvl[LVLS-1].ix[0]};
endmodule

// File: rtl/diff_unit.sv
// Registered diff unit. It reports the LSB index of the first bit where inreg1 and inreg2 differ.
// The result is available one clock after a valid request.
module diff_unit
    import diff_pkg::*;
#(
    parameter int WIDTH = DIFF_WIDTH
) (
    input logic        clk,
    input logic        rst,
    diff_unit_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] x;
    logic [IDX_W-1:0] idx;
    logic             zero;

    logic [WIDTH-1:0] out_q;
    logic             equal_q;
    logic             valid_q;

    assign x = bus.inreg1 ^ bus.inreg2;

    lsb_index #(.WIDTH(WIDTH)) u_lsb_index (
        .x    (x),
        .idx  (idx),
        .zero (zero)
    );

    // A request seen while rst is high is dropped, because reset dominates the capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            equal_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                out_q   <= WIDTH'(idx);
                equal_q <= zero;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.equal     = equal_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_diff_unit.sv
// Self-checking bench for diff_unit.
// It runs directed vectors, a reset corner sequence and random traffic against a reference model.
module tb_diff_unit;
    import diff_pkg::*;

    localparam int W = DIFF_WIDTH;

    logic clk;
    logic rst;

    diff_unit_if #(.WIDTH(W)) bus ();

    diff_unit #(.WIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run time exceeded, got no finish, required finish");
        $fatal(1);
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: plain trailing-zero count of a ^ b, with W for "no difference".
    function automatic logic [W-1:0] ref_out(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        x = a ^ b;
        for (int i = 0; i < W; i++)
            if (x[i]) return W'(i);
        return W'(W);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)", name, act, act, exp, exp);
        else
            pass_cnt++;
    endtask

    // The driver applies inputs on the falling edge, then samples 1 ns after the next rising edge.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.in_valid = v;
        bus.inreg1   = a;
        bus.inreg2   = b;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_out;
        logic         exp_eq;
    } vec_t;

    vec_t tbl[$];
    logic [W:0] exp_q[$];

    initial begin
        logic [W-1:0] hold_out;
        logic         hold_eq;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   e;
        logic         v;
        int           req_cnt;
        int           pulse_cnt;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.inreg1   = '0;
        bus.inreg2   = '0;
        #3;
        check("reset_out", bus.out, '0);
        check("reset_equal", W'(bus.equal), '0);
        check("reset_valid", W'(bus.out_valid), '0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        tbl.push_back('{32'd0, 32'd0, 32'd32, 1'b1});
        tbl.push_back('{32'd12, 32'd34, 32'd1, 1'b0});
        tbl.push_back('{32'd78, 32'd34, 32'd2, 1'b0});
        tbl.push_back('{32'd45, 32'd90, 32'd0, 1'b0});
        tbl.push_back('{32'd16, 32'd68, 32'd2, 1'b0});
        tbl.push_back('{32'd98, 32'd34, 32'd6, 1'b0});
        tbl.push_back('{32'h8000_0000, 32'd0, 32'd31, 1'b0});
        tbl.push_back('{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd32, 1'b1});
        tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 1'b0});
        for (int k = 0; k < W; k++)
            tbl.push_back('{32'd0, 32'd1 << k, W'(k), 1'b0});

        foreach (tbl[i]) begin
            step(1'b1, tbl[i].a, tbl[i].b);
            check($sformatf("vec%0d_out", i), bus.out, tbl[i].exp_out);
            check($sformatf("vec%0d_equal", i), W'(bus.equal), W'(tbl[i].exp_eq));
            check($sformatf("vec%0d_valid", i), W'(bus.out_valid), 1);
            if (i % 8 == 0) begin
                step(1'b0, ~tbl[i].a, tbl[i].b);
                check($sformatf("vec%0d_hold_out", i), bus.out, tbl[i].exp_out);
                check($sformatf("vec%0d_hold_valid", i), W'(bus.out_valid), 0);
            end
        end

        // Mid-stream reset: outputs clear at once, and a request during reset is discarded.
        step(1'b1, 32'd5, 32'd1);
        check("pre_rst_out", bus.out, 32'd2);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.inreg1   = 32'd0;
        bus.inreg2   = 32'd0;
        rst          = 1'b1;
        #1;
        check("async_rst_out", bus.out, '0);
        check("async_rst_valid", W'(bus.out_valid), 0);
        check("async_rst_equal", W'(bus.equal), 0);
        @(posedge clk);
        #1;
        check("rst_edge_valid", W'(bus.out_valid), 0);
        check("rst_edge_equal", W'(bus.equal), 0);
        @(negedge clk);
        rst          = 1'b0;
        bus.inreg1   = 32'd7;
        bus.inreg2   = 32'd3;
        @(posedge clk);
        #1;
        check("first_after_rst_out", bus.out, 32'd2);
        check("first_after_rst_valid", W'(bus.out_valid), 1);
        step(1'b0, 32'd0, 32'd0);
        check("after_first_valid", W'(bus.out_valid), 0);
        check("after_first_hold", bus.out, 32'd2);

        // Random traffic with gaps, checked against the scoreboard queue.
        hold_out  = bus.out;
        hold_eq   = bus.equal;
        req_cnt   = 0;
        pulse_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 9) < 7);
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = a;
                2: b = a ^ (32'd1 << $urandom_range(0, W - 1));
                default: b = a ^ ($urandom << $urandom_range(0, W - 1));
            endcase
            if (v) begin
                exp_q.push_back({(a == b), ref_out(a, b)});
                req_cnt++;
            end
            step(v, a, b);
            if (bus.out_valid) pulse_cnt++;
            if (v) begin
                if (exp_q.size() == 0) begin
                    check("rnd_queue_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rnd%0d_out", c), bus.out, e[W-1:0]);
                    check($sformatf("rnd%0d_equal", c), W'(bus.equal), W'(e[W]));
                    hold_out = e[W-1:0];
                    hold_eq  = e[W];
                end
                check($sformatf("rnd%0d_valid", c), W'(bus.out_valid), 1);
            end else begin
                check($sformatf("rnd%0d_hold_out", c), bus.out, hold_out);
                check($sformatf("rnd%0d_hold_equal", c), W'(bus.equal), W'(hold_eq));
                check($sformatf("rnd%0d_gap_valid", c), W'(bus.out_valid), 0);
            end
        end
        check("pulse_count", W'(pulse_cnt), W'(req_cnt));
        check("queue_drained", W'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
